// File: rtl/mac_block_accumulator.sv
// mac_block_accumulator
//   Sums blocks of 2**N_LOG2 unsigned samples from the multiply-add stage.
//   Each completed block is presented as sum and truncated mean on a
//   valid/ready output. A three-state FSM controls the block:
//   IDLE -> ACCUM -> DONE -> IDLE.
// Ports
//   clk, reset             rising-edge clock; asynchronous active-high reset
//   in_valid/in_data       input sample (2*width bits, unsigned)
//   in_ready               high in IDLE/ACCUM, low while a result is pending
//   clear                  synchronous abort of a partial block or a pending result
//   out_valid/out_ready    output handshake
//   out_sum                block sum (2*width+N_LOG2 bits, cannot overflow)
//   out_mean               out_sum >> N_LOG2
//   sample_cnt             samples accepted so far in the current block
module mac_block_accumulator #(
    parameter int width  = 8,
    parameter int N_LOG2 = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    input  logic [2*width-1:0]         in_data,
    output logic                       in_ready,
    input  logic                       clear,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [2*width+N_LOG2-1:0]  out_sum,
    output logic [2*width-1:0]         out_mean,
    output logic [N_LOG2-1:0]          sample_cnt
);
    localparam int W = 2*width + N_LOG2;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ACCUM = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    logic [1:0]   state;
    logic [W-1:0] acc;
    logic [W-1:0] sum;
    logic         accept;

    assign in_ready = (state != DONE);
    assign accept   = in_valid & in_ready;
    assign sum      = acc + W'(in_data);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            acc        <= '0;
            sample_cnt <= '0;
            out_valid  <= 1'b0;
            out_sum    <= '0;
            out_mean   <= '0;
        end else if (clear) begin
            // Abort takes priority over any accept or handshake in the same cycle.
            // out_sum/out_mean keep their old values; they are ignored while out_valid=0.
            state      <= IDLE;
            acc        <= '0;
            sample_cnt <= '0;
            out_valid  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        acc        <= W'(in_data);
                        sample_cnt <= N_LOG2'(1);
                        state      <= ACCUM;
                    end
                end
                ACCUM: begin
                    if (accept) begin
                        if (&sample_cnt) begin
                            // Last sample of the block. The result is registered on the
                            // same edge that accepts it.
                            out_sum    <= sum;
                            out_mean   <= sum[W-1:N_LOG2];
                            out_valid  <= 1'b1;
                            sample_cnt <= '0;
                            acc        <= sum;
                            state      <= DONE;
                        end else begin
                            acc        <= sum;
                            sample_cnt <= sample_cnt + N_LOG2'(1);
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        acc       <= '0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
